// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA pixel-timing generator.
// Counts pixels (hc) and lines (vc) on every ce edge. Each ce edge registers
// position, syncs, visibility and frame-start for the same pixel, so all
// outputs stay aligned with one cycle of latency from the counters.
// Optional feature: define VGA_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
`ifdef VGA_FRAME_CNT_EN
  ,
  parameter int FRAME_W   = 16
`endif
) (
  input  logic                vga_clk,
  input  logic                reset,
  input  logic                ce,
  output logic [9:0]          DrawX,
  output logic [9:0]          DrawY,
  output logic                hs,
  output logic                vs,
  output logic                blank,
  output logic                frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0]  frame_cnt
`endif
);

  // Timing landmarks, sized to the 10-bit counters.
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_start;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_hs;
  logic       w_vs;
  logic       w_visible;
  logic       w_frame_first;

  // Decode of the pixel currently held in the counters.
  assign w_h_last      = (r_hc == H_LAST);
  assign w_v_last      = (r_vc == V_LAST);
  assign w_hs          = !((r_hc >= HS_START) && (r_hc < HS_END));
  assign w_vs          = !((r_vc >= VS_START) && (r_vc < VS_END));
  assign w_visible     = (r_hc < H_VIS) && (r_vc < V_VIS);
  assign w_frame_first = (r_hc == 10'd0) && (r_vc == 10'd0);

  // Pixel/line counters: hc wraps at end of line, vc steps on each hc wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else if (ce) begin
      if (w_h_last) begin
        r_hc <= 10'd0;
        r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Output stage: register position and decoded timing for the same pixel.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_draw_x      <= 10'd0;
      r_draw_y      <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_draw_x      <= r_hc;
      r_draw_y      <= r_vc;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_blank       <= w_visible;
      r_frame_start <= w_frame_first;
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  // Frame counter: steps on the edge that presents pixel (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (ce && w_frame_first) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
